// File: rtl/pattern_editor.sv
// Cursor/edit command executor for the 80x30 pattern grid: edge-armed commands, wrapping cursor,
// and a read-modify-write (or direct delete) sequence against a one-cycle-latency pattern RAM.
module pattern_editor #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic [2:0]    user_cursor,
  input  logic [1:0]    user_edit,
  output logic [6:0]    cursor_x,
  output logic [6:0]    cursor_y,
  output logic          busy,
  output logic [11:0]   ram_addr,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          edit_done
);

  typedef enum logic [1:0] {IDLE, RD, WT, WR} state_t;

  localparam logic [6:0] X_MAX = 7'(COLS - 1);
  localparam logic [6:0] Y_MAX = 7'(ROWS - 1);

  state_t      state, next_state;
  logic        arm_cur, arm_edit, dec_op;
  logic        cur_vld, edit_vld, edit_acc, move_acc;
  logic [11:0] addr_c;

  // Codes 101..111 count as "none", so they also re-arm the cursor input.
  assign cur_vld  = (user_cursor != 3'b000) && (user_cursor <= 3'b100);
  assign edit_vld = (user_edit != 2'b00);
  assign edit_acc = (state == IDLE) && arm_edit && edit_vld;
  assign move_acc = (state == IDLE) && arm_cur && cur_vld && !edit_acc;
  assign addr_c   = ({5'd0, cursor_y} << 6) + ({5'd0, cursor_y} << 4) + {5'd0, cursor_x};

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (edit_acc) next_state = (user_edit == 2'b11) ? WR : RD;
      RD:   next_state = WT;
      WT:   next_state = WR;
      WR:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      ram_we    <= 1'b0;
      edit_done <= 1'b0;
      arm_cur   <= 1'b1;
      arm_edit  <= 1'b1;
      dec_op    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cursor_x  <= '0;
      cursor_y  <= '0;
    end else begin
      state     <= next_state;
      busy      <= (next_state != IDLE);
      ram_we    <= (next_state == WR);
      edit_done <= (next_state == WR);

      if (!cur_vld)      arm_cur <= 1'b1;
      else if (move_acc) arm_cur <= 1'b0;
      if (!edit_vld)     arm_edit <= 1'b1;
      else if (edit_acc) arm_edit <= 1'b0;

      if (edit_acc) begin
        ram_addr <= addr_c;
        dec_op   <= (user_edit == 2'b10);
        if (user_edit == 2'b11) ram_wdata <= '0;
      end
      // Read data arrives during WT; the modulo wrap falls out of the DW-bit adder.
      if (state == WT) ram_wdata <= dec_op ? ram_rdata - DW'(1) : ram_rdata + DW'(1);

      if (move_acc) begin
        case (user_cursor)
          3'b001:  cursor_x <= (cursor_x == 7'd0)  ? X_MAX : cursor_x - 7'd1;
          3'b010:  cursor_x <= (cursor_x == X_MAX) ? 7'd0  : cursor_x + 7'd1;
          3'b011:  cursor_y <= (cursor_y == 7'd0)  ? Y_MAX : cursor_y - 7'd1;
          3'b100:  cursor_y <= (cursor_y == Y_MAX) ? 7'd0  : cursor_y + 7'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pattern_editor.sv
// Directed and randomized checks of pattern_editor against a transaction-level grid/RAM model.
module tb_pattern_editor;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  user_cursor = 3'd0;
  logic [1:0]  user_edit = 2'd0;
  logic [6:0]  cursor_x, cursor_y;
  logic        busy, ram_we, edit_done;
  logic [11:0] ram_addr;
  logic [7:0]  ram_rdata = 8'd0;
  logic [7:0]  ram_wdata;

  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = 12'd0;
  logic [7:0]  pl_dat = 8'd0;
  logic [7:0]  mem [0:CELLS-1];
  logic [7:0]  ref_mem [0:CELLS-1];

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;
  logic prev_we = 1'b0;
  logic b2b = 1'b0;

  pattern_editor #(.COLS(COLS), .ROWS(ROWS), .DW(8)) dut (
    .clk(clk), .Reset(Reset), .user_cursor(user_cursor), .user_edit(user_edit),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy), .ram_addr(ram_addr),
    .ram_rdata(ram_rdata), .ram_wdata(ram_wdata), .ram_we(ram_we), .edit_done(edit_done)
  );

  always #5 clk = ~clk;

  // Synchronous-read pattern RAM with a bench-side preload port.
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_dat;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(posedge clk) begin
    if (ram_we) we_cnt <= we_cnt + 1;
    if (ram_we && prev_we) b2b <= 1'b1;
    prev_we <= ram_we;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int a, input logic [7:0] d);
    pl_addr = 12'(a);
    pl_dat  = d;
    pl_we   = 1'b1;
    tick();
    pl_we   = 1'b0;
  endtask

  task automatic press(input logic [2:0] c);
    user_cursor = c;
    tick();
    user_cursor = 3'd0;
    tick();
  endtask

  initial begin
    int x, y, w0, we_base, exp_we, bad_cells;

    // Preload every cell while the DUT is held in reset.
    for (int a = 0; a < CELLS; a++) poke(a, 8'($urandom_range(0, 255)));
    chk("rst_x", cursor_x, 0);
    chk("rst_y", cursor_y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_done", edit_done, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    Reset = 1'b0;
    tick();

    // Held left key wraps once and then stays.
    user_cursor = 3'b001;
    tick();
    chk("left_wrap", cursor_x, 79);
    repeat (9) tick();
    chk("left_held", cursor_x, 79);
    user_cursor = 3'b000;
    tick();
    press(3'b010);
    chk("right_wrap", cursor_x, 0);

    for (int i = 1; i <= 30; i++) begin
      user_cursor = 3'b100;
      tick();
      chk("down_step", cursor_y, i % 30);
      user_cursor = 3'b000;
      tick();
    end
    press(3'b011);
    chk("up_wrap", cursor_y, 29);

    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    repeat (3) press(3'b010);
    repeat (2) press(3'b100);
    chk("pos_x", cursor_x, 3);
    chk("pos_y", cursor_y, 2);

    // Increment with wrap, key held throughout.
    poke(163, 8'hFF);
    user_edit = 2'b01;
    tick();
    chk("inc_rd_busy", busy, 1);
    chk("inc_rd_we", ram_we, 0);
    chk("inc_addr", ram_addr, 163);
    tick();
    chk("inc_wt_busy", busy, 1);
    chk("inc_wt_we", ram_we, 0);
    tick();
    chk("inc_wr_we", ram_we, 1);
    chk("inc_wr_done", edit_done, 1);
    chk("inc_wr_busy", busy, 1);
    chk("inc_wdata", ram_wdata, 8'h00);
    chk("inc_wr_addr", ram_addr, 163);
    tick();
    chk("inc_idle_busy", busy, 0);
    chk("inc_idle_we", ram_we, 0);
    chk("inc_idle_done", edit_done, 0);
    repeat (3) tick();
    chk("inc_once", busy, 0);
    chk("inc_mem", mem[163], 8'h00);
    user_edit = 2'b00;
    tick();

    poke(163, 8'h00);
    user_edit = 2'b10;
    repeat (3) tick();
    chk("dec_we", ram_we, 1);
    chk("dec_wdata", ram_wdata, 8'hFF);
    user_edit = 2'b00;
    repeat (2) tick();

    poke(163, 8'h42);
    user_edit = 2'b11;
    tick();
    chk("del_we", ram_we, 1);
    chk("del_busy", busy, 1);
    chk("del_wdata", ram_wdata, 8'h00);
    tick();
    chk("del_idle", busy, 0);
    chk("del_we_off", ram_we, 0);
    user_edit = 2'b00;
    tick();

    // Move pressed during an edit is deferred until the first IDLE cycle.
    user_edit = 2'b01;
    tick();
    user_cursor = 3'b010;
    repeat (2) tick();
    chk("defer_we", ram_we, 1);
    chk("defer_addr", ram_addr, 163);
    chk("defer_x_wr", cursor_x, 3);
    tick();
    chk("defer_busy", busy, 0);
    chk("defer_x_idle", cursor_x, 3);
    tick();
    chk("defer_x_moved", cursor_x, 4);
    user_edit = 2'b00;
    user_cursor = 3'b000;
    tick();

    // Edit and move accepted together: edit uses the pre-move address.
    user_edit = 2'b11;
    user_cursor = 3'b001;
    tick();
    chk("simul_we", ram_we, 1);
    chk("simul_addr", ram_addr, 164);
    chk("simul_x_hold", cursor_x, 4);
    tick();
    chk("simul_x_wait", cursor_x, 4);
    tick();
    chk("simul_x_moved", cursor_x, 3);
    user_edit = 2'b00;
    user_cursor = 3'b000;
    tick();

    // Reset during WT aborts without a write.
    user_edit = 2'b01;
    repeat (2) tick();
    Reset = 1'b1;
    user_edit = 2'b00;
    w0 = we_cnt;
    tick();
    chk("abort_x", cursor_x, 0);
    chk("abort_y", cursor_y, 0);
    chk("abort_busy", busy, 0);
    chk("abort_we", ram_we, 0);
    chk("abort_done", edit_done, 0);
    chk("abort_addr", ram_addr, 0);
    chk("abort_wdata", ram_wdata, 0);
    Reset = 1'b0;
    repeat (3) tick();
    chk("abort_no_write", 32'(we_cnt - w0), 0);

    // Randomized transactions against a grid/RAM model.
    x = 0;
    y = 0;
    for (int a = 0; a < CELLS; a++) ref_mem[a] = mem[a];
    we_base = we_cnt;
    exp_we = 0;
    for (int t = 0; t < 200; t++) begin
      int c, e, h, bl, a;
      bit mv;
      c = $urandom_range(0, 7);
      e = $urandom_range(0, 3);
      h = $urandom_range(1, 6);
      mv = (c >= 1 && c <= 4);
      if (e != 0) begin
        a = y * COLS + x;
        case (e)
          1: ref_mem[a] = 8'((int'(ref_mem[a]) + 1) % 256);
          2: ref_mem[a] = 8'((int'(ref_mem[a]) + 255) % 256);
          default: ref_mem[a] = 8'h00;
        endcase
        exp_we++;
        bl = (e == 3) ? 1 : 3;
        if (h < bl + 2) mv = 1'b0;
      end
      if (mv) begin
        case (c)
          1: x = (x + COLS - 1) % COLS;
          2: x = (x + 1) % COLS;
          3: y = (y + ROWS - 1) % ROWS;
          default: y = (y + 1) % ROWS;
        endcase
      end
      user_cursor = 3'(c);
      user_edit = 2'(e);
      repeat (h) tick();
      user_cursor = 3'd0;
      user_edit = 2'd0;
      for (int k = 0; k < 12 && busy; k++) tick();
      chk("rnd_idle", busy, 0);
      tick();
      chk("rnd_x", cursor_x, x);
      chk("rnd_y", cursor_y, y);
    end
    chk("rnd_writes", 32'(we_cnt - we_base), exp_we);
    chk("we_never_b2b", b2b, 0);
    bad_cells = 0;
    for (int a = 0; a < CELLS; a++) if (mem[a] !== ref_mem[a]) bad_cells++;
    chk("ram_contents", bad_cells, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
